// File: rtl/mem_stage_pkg.sv
// Shared types and sizing helpers for the MEM stage ordering queue.
package mem_stage_pkg;

    localparam int DEPTH_MIN = 2;
    localparam int DEPTH_MAX = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] alu_result;
        logic [4:0]  dest;
        logic        gr_we;
        logic        res_from_mem;
        logic        req_sent;
        logic        op_b;
        logic        op_h;
        logic        op_unsigned;
        logic [31:0] rdata;
        logic        has_data;
    } mem_entry_t;

    function automatic int ptr_w(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

    // Must be able to hold the value DEPTH itself (full FIFO / full drain).
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/mem_ld_align.sv
// Load lane select and sign/zero extension for byte, half and word loads.
module mem_ld_align (
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        op_b_i,
    input  logic        op_h_i,
    input  logic        op_unsigned_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata_i[7:0];
        case (addr_lo_i)
            2'd0:    byte_lane = rdata_i[7:0];
            2'd1:    byte_lane = rdata_i[15:8];
            2'd2:    byte_lane = rdata_i[23:16];
            default: byte_lane = rdata_i[31:24];
        endcase
        half_lane = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        if (op_b_i)
            result_o = {{24{~op_unsigned_i & byte_lane[7]}}, byte_lane};
        else if (op_h_i)
            result_o = {{16{~op_unsigned_i & half_lane[15]}}, half_lane};
        else
            result_o = rdata_i;
    end

endmodule

// File: rtl/mem_stage_oq.sv
// MEM stage in-order queue: tracks in-flight loads/stores, matches data_ok responses
// in order, drains orphaned responses after flush. Define MEM_PERF_CNT_EN for the stall counter.
module mem_stage_oq
    import mem_stage_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PL_W  = 160
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            ex_valid,
    output logic            ex_allowin,
    input  logic [31:0]     ex_pc,
    input  logic [31:0]     ex_alu_result,
    input  logic [4:0]      ex_dest,
    input  logic            ex_gr_we,
    input  logic            ex_res_from_mem,
    input  logic            ex_req_sent,
    input  logic            ex_op_b,
    input  logic            ex_op_h,
    input  logic            ex_op_unsigned,
    input  logic [PL_W-1:0] ex_payload,
    input  logic [31:0]     data_sram_rdata,
    input  logic            data_sram_data_ok,
    input  logic            flush,
    output logic            wb_valid,
    input  logic            wb_allowin,
    output logic [31:0]     wb_pc,
    output logic            wb_gr_we,
    output logic [4:0]      wb_dest,
    output logic [31:0]     wb_result,
    output logic [PL_W-1:0] wb_payload,
    output logic            mem_can_issue,
    output logic            mem_busy,
    output logic [31:0]     perf_stall_cnt
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);

    if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("mem_stage_oq: DEPTH must be a power of 2 in 2..8");
    end

    logic              valid_q   [DEPTH];
    mem_entry_t        entry_q   [DEPTH];
    logic [PL_W-1:0]   payload_q [DEPTH];
    logic [PTR_W-1:0]  rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CNT_W-1:0]  count_q, count_d, drain_q, drain_d;

    logic [PTR_W-1:0]  scan_idx, tgt_idx;
    logic              tgt_found;
    logic [CNT_W-1:0]  unresolved, inflight_req;
    logic              push, pop, full, dok_consume, drain_dec;
    logic              head_valid, head_hit;
    mem_entry_t        head_entry, new_entry;
    logic [31:0]       head_rdata, ld_result;

    // Entries are contiguous from rptr, so scanning in age order finds the oldest waiter.
    always_comb begin
        scan_idx     = rptr_q;
        tgt_idx      = rptr_q;
        tgt_found    = 1'b0;
        unresolved   = '0;
        inflight_req = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = rptr_q + PTR_W'(i);
            if (valid_q[scan_idx] && entry_q[scan_idx].req_sent) begin
                inflight_req = inflight_req + CNT_W'(1);
                if (!entry_q[scan_idx].has_data) begin
                    unresolved = unresolved + CNT_W'(1);
                    if (!tgt_found) begin
                        tgt_found = 1'b1;
                        tgt_idx   = scan_idx;
                    end
                end
            end
        end
    end

    assign drain_dec   = data_sram_data_ok && (drain_q != '0);
    assign dok_consume = data_sram_data_ok && (drain_q == '0) && tgt_found;

    assign head_valid = valid_q[rptr_q];
    assign head_entry = entry_q[rptr_q];
    assign head_hit   = dok_consume && (tgt_idx == rptr_q);
    assign head_rdata = head_hit ? data_sram_rdata : head_entry.rdata;

    assign wb_valid = head_valid && (!head_entry.req_sent || head_entry.has_data || head_hit);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign pop      = wb_valid && wb_allowin;
    assign ex_allowin = !full || pop;
    assign push     = ex_valid && ex_allowin;

    mem_ld_align u_ld_align (
        .rdata_i       (head_rdata),
        .addr_lo_i     (head_entry.alu_result[1:0]),
        .op_b_i        (head_entry.op_b),
        .op_h_i        (head_entry.op_h),
        .op_unsigned_i (head_entry.op_unsigned),
        .result_o      (ld_result)
    );

    assign wb_pc      = head_entry.pc;
    assign wb_gr_we   = head_entry.gr_we;
    assign wb_dest    = head_entry.dest;
    assign wb_result  = head_entry.res_from_mem ? ld_result : head_entry.alu_result;
    assign wb_payload = payload_q[rptr_q];

    assign mem_can_issue = ({1'b0, inflight_req} + {1'b0, drain_q}) < (CNT_W + 1)'(DEPTH);
    assign mem_busy      = (count_q != '0) || (drain_q != '0);

    always_comb begin
        new_entry              = '0;
        new_entry.pc           = ex_pc;
        new_entry.alu_result   = ex_alu_result;
        new_entry.dest         = ex_dest;
        new_entry.gr_we        = ex_gr_we;
        new_entry.res_from_mem = ex_res_from_mem;
        new_entry.req_sent     = ex_req_sent;
        new_entry.op_b         = ex_op_b;
        new_entry.op_h         = ex_op_h;
        new_entry.op_unsigned  = ex_op_unsigned;
    end

    // A flushed same-cycle push still has its request in flight, so it joins the drain.
    always_comb begin
        rptr_d  = rptr_q + PTR_W'(pop);
        wptr_d  = wptr_q + PTR_W'(push);
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        drain_d = drain_q;
        if (flush) begin
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
            drain_d = drain_q - CNT_W'(drain_dec) + unresolved - CNT_W'(dok_consume)
                      + CNT_W'(push && ex_req_sent);
        end else if (drain_dec) begin
            drain_d = drain_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            drain_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            drain_q <= drain_d;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (!resetn || flush) begin
                valid_q[gi] <= 1'b0;
            end else begin
                if (pop && rptr_q == PTR_W'(gi))
                    valid_q[gi] <= 1'b0;
                if (push && wptr_q == PTR_W'(gi))
                    valid_q[gi] <= 1'b1;
            end
        end

        // Push is written last so a new entry wins over a capture into the slot just vacated.
        always_ff @(posedge clk) begin
            if (dok_consume && tgt_idx == PTR_W'(gi)) begin
                entry_q[gi].rdata    <= data_sram_rdata;
                entry_q[gi].has_data <= 1'b1;
            end
            if (push && wptr_q == PTR_W'(gi)) begin
                entry_q[gi]   <= new_entry;
                payload_q[gi] <= ex_payload;
            end
        end
    end

`ifdef MEM_PERF_CNT_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (head_valid && !wb_valid && perf_q != 32'hFFFF_FFFF)
            perf_d = perf_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!resetn)
            perf_q <= '0;
        else
            perf_q <= perf_d;
    end

    assign perf_stall_cnt = perf_q;
`else
    assign perf_stall_cnt = '0;
`endif

endmodule
